// File: rtl/naneye_pkg.sv
// Shared definitions for the NanEye frame capture controller: FSM encoding,
// error flag positions, pixel geometry defaults and the word framing check.
package naneye_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_SHORT    = 1;
  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_OVERFLOW = 3;

  localparam int NANEYE_DATA_W       = 10;
  localparam int NANEYE_FIFO_W       = NANEYE_DATA_W + 2;
  localparam int NANEYE_PIX_PER_LINE = 250;
  localparam int NANEYE_LINES        = 250;

  // A sensor word is valid only with a '1' start bit and a '0' stop bit.
  function automatic logic word_framing_ok(input logic start_bit, input logic stop_bit);
    return start_bit & ~stop_bit;
  endfunction

endpackage

// File: rtl/naneye_pix_fifo.sv
// Pixel FIFO holding {sof, eol, data}; the head entry is presented from flops so
// it stays stable under backpressure, and a push into an empty FIFO lands there directly.
module naneye_pix_fifo
  import naneye_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = NANEYE_FIFO_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_ready_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, count_left_s;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, pop_s, full_s, push_ok_s;

  // Occupancy and next head; a full FIFO still accepts a push when the head pops.
  always_comb begin
    pop_s        = valid_q & pop_ready_i;
    full_s       = (count_q == CW'(DEPTH));
    push_ok_s    = push_i & (~full_s | pop_s);
    count_left_s = count_q - CW'(pop_s);
    count_d      = count_left_s + CW'(push_ok_s);
    rd_ptr_d     = rd_ptr_q + AW'(pop_s);
    head_d       = (count_left_s == CW'(0)) ? push_data_i : mem_q[rd_ptr_d];
  end

  // Storage array; contents need no reset because count_q guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, count and the registered head.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      valid_q  <= 1'b0;
      head_q   <= W'(0);
    end else if (flush_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      valid_q  <= 1'b0;
      head_q   <= W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != CW'(0));
      if (count_d != CW'(0)) begin
        head_q <= head_d;
      end
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign empty_o = (count_q == CW'(0));
  assign drop_o  = push_i & ~push_ok_s & ~flush_i;

endmodule

// File: rtl/naneye_frame_ctrl.sv
// NanEye frame capture controller: sequences one frame per arm, assembles serial
// sensor words into pixels and supervises framing, frame window and bit timeout.
module naneye_frame_ctrl
  import naneye_pkg::*;
#(
  parameter int PIX_PER_LINE = NANEYE_PIX_PER_LINE,
  parameter int LINES        = NANEYE_LINES,
  parameter int WORD_BITS    = 12,
  parameter int TIMEOUT      = 1023,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     SCLOCK,
  input  logic                     RESET,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     frame_sync_start,
  input  logic                     S_DATA,
  input  logic                     S_WREN,
  output logic [NANEYE_DATA_W-1:0] pix_data,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [3:0]               err_flags
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int PW = $clog2(PIX_PER_LINE + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [WORD_BITS-2:0]     sr_q, sr_d;
  logic [WORD_BITS-1:0]     word_s;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]            pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]            line_cnt_q, line_cnt_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [NANEYE_FIFO_W-1:0] push_word_q, push_word_d, fifo_head_s;
  logic [3:0]               err_q, err_d;
  logic                     sync_q, sof_pend_q, sof_pend_d, push_q, push_d;
  logic                     busy_q, done_q, done_d, flush_s, line_end_s;
  logic                     fifo_empty_s, fifo_drop_s;

  // Next-state logic for the capture sequencer and its datapath.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    tmo_d       = tmo_q;
    sof_pend_d  = sof_pend_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    done_d      = 1'b0;
    flush_s     = 1'b0;
    err_d       = err_q;
    err_d[ERR_OVERFLOW] = err_q[ERR_OVERFLOW] | fifo_drop_s;
    word_s      = {sr_q, S_DATA};
    line_end_s  = (pix_cnt_q == PW'(PIX_PER_LINE - 1));
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_WAIT_SYNC;
          err_d      = 4'b0000;
          flush_s    = 1'b1;
          sr_d       = '0;
          bit_cnt_d  = BW'(0);
          pix_cnt_d  = PW'(0);
          line_cnt_d = LW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (abort) begin
          state_d = ST_FAIL;
        end else if (frame_sync_start && !sync_q) begin
          state_d    = ST_CAPTURE;
          tmo_d      = TW'(0);
          bit_cnt_d  = BW'(0);
          sof_pend_d = 1'b1;
        end else begin
          state_d = ST_WAIT_SYNC;
        end
      end
      ST_CAPTURE: begin
        tmo_d = S_WREN ? TW'(0) : tmo_q + TW'(1);
        if (abort) begin
          state_d = ST_FAIL;
        end else if (S_WREN) begin
          sr_d = word_s[WORD_BITS-2:0];
          if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
            bit_cnt_d = BW'(0);
            if (word_framing_ok(word_s[WORD_BITS-1], word_s[0])) begin
              push_d      = 1'b1;
              push_word_d = {sof_pend_q, line_end_s, word_s[NANEYE_DATA_W:1]};
              sof_pend_d  = 1'b0;
              if (line_end_s) begin
                pix_cnt_d  = PW'(0);
                line_cnt_d = line_cnt_q + LW'(1);
                state_d    = (line_cnt_q == LW'(LINES - 1)) ? ST_FLUSH : ST_CAPTURE;
              end else begin
                pix_cnt_d = pix_cnt_q + PW'(1);
              end
            end else begin
              err_d[ERR_FRAMING] = 1'b1;
              state_d            = ST_FAIL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if (!frame_sync_start) begin
          err_d[ERR_SHORT] = 1'b1;
          state_d          = ST_FAIL;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_FAIL;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_FLUSH: begin
        // The last pixel may still be in flight to the FIFO when FLUSH begins.
        if (abort) begin
          state_d = ST_FAIL;
        end else if (fifo_empty_s && !push_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FAIL: begin
        flush_s = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= BW'(0);
      pix_cnt_q   <= PW'(0);
      line_cnt_q  <= LW'(0);
      tmo_q       <= TW'(0);
      sync_q      <= 1'b0;
      sof_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      tmo_q       <= tmo_d;
      sync_q      <= frame_sync_start;
      sof_pend_q  <= sof_pend_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  naneye_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (NANEYE_FIFO_W)
  ) u_fifo (
    .clk_i       (SCLOCK),
    .rst_n_i     (RESET),
    .flush_i     (flush_s),
    .push_i      (push_q),
    .push_data_i (push_word_q),
    .pop_ready_i (pix_ready),
    .head_o      (fifo_head_s),
    .valid_o     (pix_valid),
    .empty_o     (fifo_empty_s),
    .drop_o      (fifo_drop_s)
  );

  assign pix_sof    = fifo_head_s[NANEYE_FIFO_W-1];
  assign pix_eol    = fifo_head_s[NANEYE_FIFO_W-2];
  assign pix_data   = fifo_head_s[NANEYE_DATA_W-1:0];
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_flags  = err_q;

endmodule

// File: doc/naneye_frame_ctrl.md
# naneye_frame_ctrl

Frame capture controller that sits downstream of the NanEye Manchester decoder. It sequences capture of one image frame per arm request, and assembles decoded bits (S_DATA qualified by S_WREN) into 12-bit sensor words. It checks start/stop framing, counts pixels and lines, and hands 10-bit pixels to the memory writer through a valid/ready FIFO. It also supervises the decoder's frame window (frame_sync_start) and aborts on timeout or framing loss.

## Interface
Parameters:
- PIX_PER_LINE, 250, pixels per line
- LINES, 250, lines per frame
- WORD_BITS, 12, serial word length: start '1' + 10 data bits (MSB first) + stop '0'
- TIMEOUT, 1023, max SCLOCK cycles between S_WREN pulses during capture
- FIFO_DEPTH, 4, output buffer depth (power of two)

Ports:
- SCLOCK  in  1  sensor-domain clock
- RESET  in  1  asynchronous, active-low
- arm  in  1  one-cycle request to capture the next frame
- abort  in  1  one-cycle request to cancel capture
- frame_sync_start  in  1  decoder frame window, high while decoding data
- S_DATA  in  1  decoded bit
- S_WREN  in  1  S_DATA valid strobe (single cycle)
- pix_data  out  10  pixel value
- pix_sof  out  1  first pixel of frame, qualified by pix_valid
- pix_eol  out  1  last pixel of line, qualified by pix_valid
- pix_valid  out  1  FIFO head valid
- pix_ready  in  1  downstream accepts head when pix_valid&pix_ready
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse: frame completed cleanly
- err_flags  out  4  sticky {overflow, timeout, short_frame, framing}; cleared on arm

## Operation
- States: IDLE, WAIT_SYNC, CAPTURE, FLUSH, FAIL.
- IDLE: arm -> WAIT_SYNC. The arm pulse clears err_flags, the bit, pixel and line counters, and the FIFO.
- WAIT_SYNC: waits for the rising edge of frame_sync_start -> CAPTURE. A level already high at arm time is not accepted; the bench must see a fresh rise.
- CAPTURE: each S_WREN shifts S_DATA into a 12-bit shift register and increments bit_cnt (0..WORD_BITS-1). At bit_cnt = WORD_BITS-1 the word is complete:
  - First bit '1' and last bit '0': push the 10 data bits, increment pix_cnt. At PIX_PER_LINE-1, wrap pix_cnt to 0, set eol, increment line_cnt.
  - Otherwise: set framing flag and drop the word. The counters do not advance.
- Exit from CAPTURE:
  - Last pixel of line LINES-1 pushed -> FLUSH.
  - frame_sync_start falls before that -> set short_frame, go to FAIL.
  - Framing error or timeout -> FAIL.
- The pixel pushed first after entering CAPTURE carries sof. The eol bit is stored alongside the pixel in the FIFO.
- FLUSH: waits until the FIFO is empty, pulses frame_done, then -> IDLE.
- FAIL: flushes the FIFO immediately (drops contents), then -> IDLE. frame_done stays 0.
- abort in any non-IDLE state -> FAIL. arm outside IDLE is ignored.
- Overflow: a push while the FIFO is full drops the pixel and sets the overflow flag. Capture continues and counters advance.
- Timeout: in CAPTURE, a cycle counter resets on every S_WREN. Reaching TIMEOUT sets the timeout flag.
- Simultaneous push and pop on a full FIFO is allowed and is not an overflow. Simultaneous abort and frame completion: abort wins.

## Timing
- Reset values: pix_data=0, pix_sof=0, pix_eol=0, pix_valid=0, busy=0, frame_done=0, err_flags=0, state IDLE.
- Latency: the S_WREN of the final bit of a word at cycle N gives pix_valid=1 at N+2 when the FIFO was empty. One cycle goes to word check/push, one to FIFO output register.
- FIFO head is registered. pix_data, pix_sof and pix_eol are stable while pix_valid=1 and pix_ready=0.
- frame_done asserts the cycle after the FIFO becomes empty in FLUSH. busy drops the same cycle frame_done is high.
- err_flags update one cycle after the causing event.
- Reset mid-frame: all state clears asynchronously and FIFO contents are lost.

## Structure
- Shared package naneye_pkg:
  - state encoding
  - err_flags bit indices
  - NANEYE_DATA_W=10
  - default PIX_PER_LINE/LINES constants
- Sub-module naneye_pix_fifo: synchronous FIFO of FIFO_DEPTH entries × 12 bits {sof, eol, data}, with full, empty, flush, and a registered output.
- Top block holds the FSM, shift register, counters, timeout counter and error logic.

## Test plan
- Clean frame, PIX_PER_LINE=4, LINES=2, pix_ready=1: arm, sync rise, 8 valid words (data 0x001..0x008) -> 8 pixels in order, sof on 0x001, eol on 0x004 and 0x008, one frame_done, err_flags=0.
- Framing error: third word stop bit = '1' -> err_flags=4'b0001, no frame_done, busy=0 within FIFO_DEPTH+2 cycles, pix_valid=0.
- Backpressure, pix_ready=0 for entire frame, FIFO_DEPTH=4, 8 pixels -> first 4 held stable, err_flags[3]=1. Release ready -> exactly 4 pixels out, then frame_done.
- Timeout, TIMEOUT=16: stop S_WREN mid-word -> err_flags[2]=1 exactly 17 cycles after last S_WREN, then IDLE.
- Short frame: frame_sync_start falls after 5 of 8 pixels -> err_flags[1]=1, no frame_done.
- Abort and reset:
  - abort in WAIT_SYNC -> IDLE in 2 cycles.
  - RESET low mid-CAPTURE -> all outputs at reset values.
  - Next arm with a fresh sync rise captures normally.
